// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the multi-channel FIR stream controller:
// FSM states, MMIO register offsets and CTRL/STATUS bit positions.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [7:0] ADDR_CTRL      = 8'h00;
  localparam logic [7:0] ADDR_STATUS    = 8'h04;
  localparam logic [7:0] ADDR_TAP_COUNT = 8'h08;
  localparam logic [7:0] ADDR_COEFF     = 8'h0C;
  localparam logic [7:0] ADDR_X_BASE    = 8'h10;
  localparam logic [7:0] ADDR_IRQ_MASK  = 8'h20;
  localparam logic [7:0] ADDR_Y_BASE    = 8'h40;

  localparam int unsigned CTRL_RUN        = 0;
  localparam int unsigned CTRL_COEFF_WREN = 1;
  localparam int unsigned CTRL_SOFT_CLEAR = 31;

  localparam int unsigned STAT_IDLE       = 0;
  localparam int unsigned STAT_LOADING    = 1;
  localparam int unsigned STAT_RUNNING    = 2;
  localparam int unsigned STAT_DRAINING   = 3;
  localparam int unsigned STAT_FIFO_EMPTY = 4;
  localparam int unsigned STAT_FIFO_FULL  = 5;
  localparam int unsigned STAT_OVERFLOW   = 6;
  localparam int unsigned STAT_Y_OVERRUN  = 7;
  localparam int unsigned STAT_TAP_ERR    = 8;
  localparam int unsigned STAT_LEVEL_LSB  = 9;
  localparam int unsigned STAT_LEVEL_MSB  = 15;
  localparam int unsigned STAT_RESULT     = 16;

endpackage

// File: rtl/fir_ctrl_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// A push while full is accepted only when a pop happens in the same cycle.
module fir_ctrl_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + LW'(1);
      else if (!do_push && do_pop) count <= count - LW'(1);
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fir_stream_ctrl.sv
// Multi-channel adaptive-FIR control unit: MMIO decode, coefficient loading,
// sample FIFO/issue and per-channel results. Define FIR_CTRL_IRQ_EN for irq/IRQ_MASK.
module fir_stream_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_TAPS   = 16,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned TC_W  = $clog2(MAX_TAPS + 1),
  localparam int unsigned IDX_W = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              reg_wr_en,
  input  logic [7:0]        reg_wr_addr,
  input  logic [DATA_W-1:0] reg_wr_data,
  input  logic              reg_rd_en,
  input  logic [7:0]        reg_rd_addr,
  output logic [DATA_W-1:0] reg_rd_data,
  output logic [TC_W-1:0]   tap_count,
  output logic [DATA_W-1:0] coeff_data,
  output logic [IDX_W-1:0]  coeff_idx,
  output logic [CH_W-1:0]   coeff_ch,
  output logic              coeff_valid,
  output logic [DATA_W-1:0] x_data,
  output logic [CH_W-1:0]   x_ch,
  output logic              x_valid,
  input  logic              x_ready,
  input  logic [DATA_W-1:0] y_data,
  input  logic [CH_W-1:0]   y_ch,
  input  logic              y_valid
`ifdef FIR_CTRL_IRQ_EN
  , output logic            irq
`endif
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OUT_W = $clog2(FIFO_DEPTH + MAX_TAPS) + 1;
  localparam int unsigned FW    = CH_W + DATA_W;

  state_e             state, state_next;
  logic               run, coeff_wren;
  logic [IDX_W-1:0]   idx;
  logic [CH_W-1:0]    ch;
  logic [OUT_W-1:0]   outstanding;
  logic [DATA_W-1:0]  result [NUM_CH];
  logic [NUM_CH-1:0]  result_valid;
  logic               overflow, y_overrun, tap_err;
  logic               st_idle, st_load, st_run, st_drain, x_issue;
  logic               wr_ctrl, soft_clear, wr_tap, tap_ok, wr_coeff, wr_x, rd_y;
  logic               coeff_accept, idx_last, load_last, y_hit, y_dec;
  logic [7:0]         x_off, y_off;
  logic [CH_W-1:0]    x_wr_ch, y_rd_ch;
  logic               fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [FW-1:0]      fifo_head;
  logic [LVL_W-1:0]   fifo_level;
  logic [DATA_W-1:0]  status, rd_mux;
`ifdef FIR_CTRL_IRQ_EN
  logic [1:0]         irq_mask;
`endif

  // Register access decode
  assign x_off        = reg_wr_addr - ADDR_X_BASE;
  assign y_off        = reg_rd_addr - ADDR_Y_BASE;
  assign x_wr_ch      = CH_W'(x_off[7:2]);
  assign y_rd_ch      = CH_W'(y_off[7:2]);
  assign wr_ctrl      = reg_wr_en && (reg_wr_addr == ADDR_CTRL);
  assign soft_clear   = wr_ctrl && reg_wr_data[CTRL_SOFT_CLEAR];
  assign wr_tap       = reg_wr_en && (reg_wr_addr == ADDR_TAP_COUNT);
  assign tap_ok       = (reg_wr_data != '0) && (reg_wr_data <= DATA_W'(MAX_TAPS));
  assign wr_coeff     = reg_wr_en && (reg_wr_addr == ADDR_COEFF);
  assign wr_x         = reg_wr_en && (reg_wr_addr >= ADDR_X_BASE) &&
                        (x_off < 8'(4 * NUM_CH)) && (x_off[1:0] == 2'b00);
  assign rd_y         = reg_rd_en && (reg_rd_addr >= ADDR_Y_BASE) &&
                        (y_off < 8'(4 * NUM_CH)) && (y_off[1:0] == 2'b00);
  assign coeff_accept = st_load && wr_coeff && coeff_wren;
  assign idx_last     = (TC_W'(idx) == tap_count - TC_W'(1));
  assign load_last    = coeff_accept && idx_last && (ch == CH_W'(NUM_CH - 1));
  assign y_hit        = y_valid && (32'(y_ch) < 32'(NUM_CH));
  assign y_dec        = y_valid && (outstanding != '0);

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (wr_tap && tap_ok) state_next = ST_LOAD;
      ST_LOAD:  if (load_last) state_next = ST_RUN;
      ST_RUN:   if (wr_ctrl && !reg_wr_data[CTRL_RUN]) state_next = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && (outstanding == '0)) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (soft_clear) state_next = ST_IDLE;
  end

  // Draining issues samples even though run is already cleared
  always_comb begin
    st_idle  = 1'b0;
    st_load  = 1'b0;
    st_run   = 1'b0;
    st_drain = 1'b0;
    x_issue  = 1'b0;
    case (state)
      ST_IDLE:  st_idle = 1'b1;
      ST_LOAD:  st_load = 1'b1;
      ST_RUN:   begin st_run = 1'b1; x_issue = run; end
      ST_DRAIN: begin st_drain = 1'b1; x_issue = 1'b1; end
      default:  st_idle = 1'b1;
    endcase
  end

  fir_ctrl_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clear (soft_clear),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({x_wr_ch, reg_wr_data}),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign fifo_push = wr_x && st_run;
  assign x_valid   = x_issue && !fifo_empty;
  assign fifo_pop  = x_valid && x_ready;
  assign x_data    = x_valid ? fifo_head[DATA_W-1:0] : '0;
  assign x_ch      = x_valid ? fifo_head[FW-1 -: CH_W] : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      run          <= 1'b0;
      coeff_wren   <= 1'b0;
      tap_count    <= '0;
      idx          <= '0;
      ch           <= '0;
      tap_err      <= 1'b0;
      overflow     <= 1'b0;
      y_overrun    <= 1'b0;
      outstanding  <= '0;
      result_valid <= '0;
      coeff_valid  <= 1'b0;
      coeff_data   <= '0;
      coeff_idx    <= '0;
      coeff_ch     <= '0;
    end else begin
      coeff_valid <= 1'b0;
      if (wr_ctrl) begin
        run        <= reg_wr_data[CTRL_RUN];
        coeff_wren <= reg_wr_data[CTRL_COEFF_WREN];
      end
      if (wr_tap) begin
        if (st_idle && tap_ok) begin
          tap_count <= TC_W'(reg_wr_data);
          idx       <= '0;
          ch        <= '0;
        end else begin
          tap_err <= 1'b1;
        end
      end
      if (coeff_accept) begin
        coeff_valid <= 1'b1;
        coeff_data  <= reg_wr_data;
        coeff_idx   <= idx;
        coeff_ch    <= ch;
        if (idx_last) begin
          idx <= '0;
          ch  <= ch + CH_W'(1);
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
      if (fifo_push && fifo_full && !fifo_pop) overflow <= 1'b1;
      if (fifo_pop && !y_dec)      outstanding <= outstanding + OUT_W'(1);
      else if (!fifo_pop && y_dec) outstanding <= outstanding - OUT_W'(1);
      // A same-cycle result on the channel being read wins over the read clear
      if (rd_y) result_valid[y_rd_ch] <= 1'b0;
      if (y_hit) begin
        result_valid[y_ch] <= 1'b1;
        if (result_valid[y_ch]) y_overrun <= 1'b1;
      end
      if (soft_clear) begin
        run          <= 1'b0;
        coeff_wren   <= 1'b0;
        tap_err      <= 1'b0;
        overflow     <= 1'b0;
        y_overrun    <= 1'b0;
        outstanding  <= '0;
        result_valid <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int c = 0; c < NUM_CH; c++) result[c] <= '0;
    end else if (y_hit) begin
      result[y_ch] <= y_data;
    end
  end

  always_comb begin
    status                                  = '0;
    status[STAT_IDLE]                       = st_idle;
    status[STAT_LOADING]                    = st_load;
    status[STAT_RUNNING]                    = st_run;
    status[STAT_DRAINING]                   = st_drain;
    status[STAT_FIFO_EMPTY]                 = fifo_empty;
    status[STAT_FIFO_FULL]                  = fifo_full;
    status[STAT_OVERFLOW]                   = overflow;
    status[STAT_Y_OVERRUN]                  = y_overrun;
    status[STAT_TAP_ERR]                    = tap_err;
    status[STAT_LEVEL_MSB:STAT_LEVEL_LSB]   = 7'(fifo_level);
    status[STAT_RESULT +: NUM_CH]           = result_valid;
    rd_mux = '0;
    if (rd_y) begin
      rd_mux = result[y_rd_ch];
    end else begin
      case (reg_rd_addr)
        ADDR_CTRL: begin
          rd_mux[CTRL_RUN]        = run;
          rd_mux[CTRL_COEFF_WREN] = coeff_wren;
        end
        ADDR_STATUS:    rd_mux = status;
        ADDR_TAP_COUNT: rd_mux = DATA_W'(tap_count);
`ifdef FIR_CTRL_IRQ_EN
        ADDR_IRQ_MASK:  rd_mux = DATA_W'(irq_mask);
`endif
        default:        rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)          reg_rd_data <= '0;
    else if (reg_rd_en) reg_rd_data <= rd_mux;
  end

`ifdef FIR_CTRL_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (reg_wr_en && (reg_wr_addr == ADDR_IRQ_MASK)) irq_mask <= reg_wr_data[1:0];
      irq <= (irq_mask[0] & (|result_valid)) |
             (irq_mask[1] & (overflow | y_overrun | tap_err));
    end
  end
`endif

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed self-checking bench for fir_stream_ctrl (default parameters).
// Builds with or without FIR_CTRL_IRQ_EN.
module tb_fir_stream_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        reg_wr_en;
  logic [7:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic        reg_rd_en;
  logic [7:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic [4:0]  tap_count;
  logic [31:0] coeff_data;
  logic [3:0]  coeff_idx;
  logic [1:0]  coeff_ch;
  logic        coeff_valid;
  logic [31:0] x_data;
  logic [1:0]  x_ch;
  logic        x_valid;
  logic        x_ready;
  logic [31:0] y_data;
  logic [1:0]  y_ch;
  logic        y_valid;
`ifdef FIR_CTRL_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] rdv;

  fir_stream_ctrl dut (
    .clk(clk), .rstn(rstn),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .tap_count(tap_count),
    .coeff_data(coeff_data), .coeff_idx(coeff_idx), .coeff_ch(coeff_ch), .coeff_valid(coeff_valid),
    .x_data(x_data), .x_ch(x_ch), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_ch(y_ch), .y_valid(y_valid)
`ifdef FIR_CTRL_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    reg_wr_en = 1'b1; reg_wr_addr = a; reg_wr_data = d;
    tick();
    reg_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    reg_rd_en = 1'b1; reg_rd_addr = a;
    tick();
    reg_rd_en = 1'b0;
    d = reg_rd_data;
  endtask

  task automatic y_pulse(input logic [1:0] c, input logic [31:0] d);
    y_valid = 1'b1; y_ch = c; y_data = d;
    tick();
    y_valid = 1'b0;
  endtask

  task automatic load_all();
    wr(8'h00, 32'h2);
    wr(8'h08, 32'd3);
    for (int i = 0; i < 12; i++) wr(8'h0C, 32'h100 + 32'(i));
  endtask

  task automatic test_reset();
    rstn = 1'b0; reg_wr_en = 1'b0; reg_wr_addr = '0; reg_wr_data = '0;
    reg_rd_en = 1'b0; reg_rd_addr = '0; x_ready = 1'b0;
    y_valid = 1'b0; y_ch = '0; y_data = '0;
    repeat (3) tick();
    checks++; if (reg_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h exp 0", reg_rd_data); end
    rstn = 1'b1;
    tick();
    checks++; if (tap_count !== 5'd0) begin errors++; $display("FAIL reset_tap_count: got %0d exp 0", tap_count); end
    checks++; if (coeff_valid !== 1'b0 || x_valid !== 1'b0) begin errors++; $display("FAIL reset_valids: coeff_valid %b x_valid %b exp 0 0", coeff_valid, x_valid); end
    rd(8'h04, rdv);
    checks++; if (rdv !== 32'h11) begin errors++; $display("FAIL reset_status: got %h exp 00000011", rdv); end
  endtask

  task automatic test_tap_err();
    wr(8'h08, 32'd0);
    checks++; if (coeff_valid !== 1'b0) begin errors++; $display("FAIL tap0_coeff_valid: got %b exp 0", coeff_valid); end
    wr(8'h08, 32'd17);
    rd(8'h04, rdv);
    checks++; if (rdv !== 32'h111) begin errors++; $display("FAIL tap_err_status: got %h exp 00000111", rdv); end
    checks++; if (tap_count !== 5'd0) begin errors++; $display("FAIL tap_err_count: got %0d exp 0", tap_count); end
    wr(8'h00, 32'h8000_0000);
    rd(8'h04, rdv);
    checks++; if (rdv !== 32'h11) begin errors++; $display("FAIL tap_err_cleared: got %h exp 00000011", rdv); end
  endtask

  task automatic test_load();
    wr(8'h00, 32'h2);
    wr(8'h08, 32'd3);
    checks++; if (tap_count !== 5'd3) begin errors++; $display("FAIL load_tap_count: got %0d exp 3", tap_count); end
    rd(8'h04, rdv);
    checks++; if (rdv !== 32'h12) begin errors++; $display("FAIL load_status: got %h exp 00000012", rdv); end
    wr(8'h00, 32'h0);
    wr(8'h0C, 32'hDEAD);
    checks++; if (coeff_valid !== 1'b0) begin errors++; $display("FAIL load_wren0: coeff_valid %b exp 0", coeff_valid); end
    wr(8'h00, 32'h2);
    for (int i = 0; i < 12; i++) begin
      wr(8'h0C, 32'h100 + 32'(i));
      checks++;
      if (coeff_valid !== 1'b1 || coeff_ch !== 2'(i / 3) || coeff_idx !== 4'(i % 3) || coeff_data !== 32'h100 + 32'(i)) begin
        errors++;
        $display("FAIL load_coeff_%0d: valid %b ch %0d idx %0d data %h exp 1 %0d %0d %h",
                 i, coeff_valid, coeff_ch, coeff_idx, coeff_data, i / 3, i % 3, 32'h100 + 32'(i));
      end
    end
    tick();
    checks++; if (coeff_valid !== 1'b0) begin errors++; $display("FAIL load_pulse_width: coeff_valid %b exp 0", coeff_valid); end
    rd(8'h04, rdv);
    checks++; if (rdv !== 32'h14) begin errors++; $display("FAIL load_to_run: got %h exp 00000014", rdv); end
  endtask

  task automatic test_overflow();
    wr(8'h00, 32'h1);
    x_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr(8'h10 + 8'(4 * (i % 4)), 32'hA000 + 32'(i));
      if (i == 0) begin
        checks++;
        if (x_valid !== 1'b1 || x_data !== 32'hA000 || x_ch !== 2'd0) begin
          errors++; $display("FAIL fwft_first: valid %b data %h ch %0d exp 1 0000a000 0", x_valid, x_data, x_ch);
        end
      end
    end
    rd(8'h04, rdv);
    checks++; if (rdv !== 32'h1064) begin errors++; $display("FAIL overflow_status: got %h exp 00001064", rdv); end
    x_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (x_valid !== 1'b1 || x_data !== 32'hA000 + 32'(k) || x_ch !== 2'(k % 4)) begin
        errors++; $display("FAIL issue_%0d: valid %b data %h ch %0d exp 1 %h %0d", k, x_valid, x_data, x_ch, 32'hA000 + 32'(k), k % 4);
      end
      tick();
    end
    checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL issue_empty: x_valid %b exp 0", x_valid); end
    x_ready = 1'b0;
  endtask

  task automatic test_soft_clear();
    wr(8'h14, 32'h55);
    wr(8'h18, 32'h66);
    checks++; if (x_valid !== 1'b1 || x_data !== 32'h55 || x_ch !== 2'd1) begin errors++; $display("FAIL sc_pre: valid %b data %h ch %0d exp 1 00000055 1", x_valid, x_data, x_ch); end
    wr(8'h00, 32'h8000_0001);
    checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL sc_x_valid: got %b exp 0", x_valid); end
    checks++; if (tap_count !== 5'd3) begin errors++; $display("FAIL sc_tap_count: got %0d exp 3", tap_count); end
    rd(8'h04, rdv);
    checks++; if (rdv !== 32'h11) begin errors++; $display("FAIL sc_status: got %h exp 00000011", rdv); end
    rd(8'h00, rdv);
    checks++; if (rdv !== 32'h0) begin errors++; $display("FAIL sc_ctrl: got %h exp 0", rdv); end
  endtask

  task automatic test_results();
    y_pulse(2'd2, 32'h1111);
    y_pulse(2'd2, 32'h2222);
    rd(8'h04, rdv);
    checks++; if (rdv !== 32'h40091) begin errors++; $display("FAIL y_overrun_status: got %h exp 00040091", rdv); end
    rd(8'h48, rdv);
    checks++; if (rdv !== 32'h2222) begin errors++; $display("FAIL y_read_ch2: got %h exp 00002222", rdv); end
    rd(8'h04, rdv);
    checks++; if (rdv !== 32'h91) begin errors++; $display("FAIL y_read_clears: got %h exp 00000091", rdv); end
    y_pulse(2'd1, 32'h3333);
    reg_rd_en = 1'b1; reg_rd_addr = 8'h44;
    y_valid = 1'b1; y_ch = 2'd1; y_data = 32'h4444;
    tick();
    reg_rd_en = 1'b0; y_valid = 1'b0;
    checks++; if (reg_rd_data !== 32'h3333) begin errors++; $display("FAIL y_same_cycle_old: got %h exp 00003333", reg_rd_data); end
    rd(8'h04, rdv);
    checks++; if (rdv !== 32'h20091) begin errors++; $display("FAIL y_same_cycle_valid: got %h exp 00020091", rdv); end
    rd(8'h44, rdv);
    checks++; if (rdv !== 32'h4444) begin errors++; $display("FAIL y_same_cycle_new: got %h exp 00004444", rdv); end
    rd(8'h30, rdv);
    checks++; if (rdv !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h exp 0", rdv); end
    wr(8'h00, 32'h8000_0000);
  endtask

  task automatic test_drain();
    load_all();
    wr(8'h00, 32'h1);
    x_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(4 * (i % 4)), 32'hB000 + 32'(i));
    x_ready = 1'b1;
    tick();
    tick();
    x_ready = 1'b0;
    checks++; if (x_data !== 32'hB002 || x_ch !== 2'd2) begin errors++; $display("FAIL drain_head: data %h ch %0d exp 0000b002 2", x_data, x_ch); end
    wr(8'h00, 32'h0);
    rd(8'h04, rdv);
    checks++; if (rdv !== 32'h608) begin errors++; $display("FAIL drain_enter: got %h exp 00000608", rdv); end
    checks++; if (x_valid !== 1'b1) begin errors++; $display("FAIL drain_issue: x_valid %b exp 1", x_valid); end
    x_ready = 1'b1;
    repeat (3) tick();
    x_ready = 1'b0;
    rd(8'h04, rdv);
    checks++; if (rdv !== 32'h18) begin errors++; $display("FAIL drain_wait_out: got %h exp 00000018", rdv); end
    for (int c = 0; c < 4; c++) y_pulse(2'(c), 32'hC000 + 32'(c));
    rd(8'h04, rdv);
    checks++; if (rdv !== 32'hF0018) begin errors++; $display("FAIL drain_one_left: got %h exp 000f0018", rdv); end
    y_pulse(2'd0, 32'hC004);
    rd(8'h04, rdv);
    checks++; if (rdv !== 32'hF0098) begin errors++; $display("FAIL drain_last_cycle: got %h exp 000f0098", rdv); end
    rd(8'h04, rdv);
    checks++; if (rdv !== 32'hF0091) begin errors++; $display("FAIL drain_to_idle: got %h exp 000f0091", rdv); end
    wr(8'h00, 32'h8000_0000);
  endtask

  task automatic test_irq();
`ifdef FIR_CTRL_IRQ_EN
    load_all();
    wr(8'h00, 32'h1);
    x_ready = 1'b0;
    wr(8'h20, 32'h2);
    for (int i = 0; i < 8; i++) wr(8'h10, 32'hD000 + 32'(i));
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b exp 0", irq); end
    wr(8'h10, 32'hD008);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency: got %b exp 0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_overflow: got %b exp 1", irq); end
    wr(8'h00, 32'h8000_0000);
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b exp 0", irq); end
`else
    wr(8'h20, 32'h3);
    rd(8'h20, rdv);
    checks++; if (rdv !== 32'h0) begin errors++; $display("FAIL irq_mask_absent: got %h exp 0", rdv); end
`endif
  endtask

  initial begin
    test_reset();
    test_tap_err();
    test_load();
    test_overflow();
    test_soft_clear();
    test_results();
    test_drain();
    test_irq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
